// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer: control codes,
// function-field encodings and the sequencer state type.
package alu_ctrl_pkg;

    // 4-bit ALU control codes
    localparam logic [3:0] AND     = 4'b0000;
    localparam logic [3:0] OR      = 4'b0001;
    localparam logic [3:0] ADD     = 4'b0010;
    localparam logic [3:0] MUL     = 4'b0011;
    localparam logic [3:0] DIV     = 4'b0100;
    localparam logic [3:0] SUB     = 4'b0110;
    localparam logic [3:0] SLT     = 4'b0111;
    localparam logic [3:0] MEM_W   = 4'b1000;
    localparam logic [3:0] MEM_H   = 4'b1001;
    localparam logic [3:0] SLL     = 4'b1010;
    localparam logic [3:0] SRL     = 4'b1011;
    localparam logic [3:0] NOR     = 4'b1100;
    localparam logic [3:0] ILLEGAL = 4'b1111;

    // Funct encodings used with ALU_op = 00 (memory access)
    localparam logic [5:0] FN_LB   = 6'h20;
    localparam logic [5:0] FN_LH   = 6'h21;
    localparam logic [5:0] FN_LW   = 6'h23;
    localparam logic [5:0] FN_SB   = 6'h28;
    localparam logic [5:0] FN_SH   = 6'h29;
    localparam logic [5:0] FN_SW   = 6'h2B;

    // Funct encodings used with ALU_op = 10 (register / immediate ops)
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADDI = 6'h08;
    localparam logic [5:0] FN_SLTI = 6'h0A;
    localparam logic [5:0] FN_ANDI = 6'h0C;
    localparam logic [5:0] FN_ORI  = 6'h0D;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_MUL  = 6'h1C;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Request/result bundle between the main control unit (master) and the
// ALU control sequencer (slave).
interface alu_ctrl_seq_if #(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic             ready_out;
    logic [1:0]       ALU_op;
    logic [5:0]       Funct;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_control;
    logic             ctrl_valid;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    logic             illegal;

    modport master (
        output valid_in, ALU_op, Funct, A, B,
        input  ready_out, ALU_control, ctrl_valid, busy, done,
               hi, lo, div_by_zero, illegal
    );

    modport slave (
        input  valid_in, ALU_op, Funct, A, B,
        output ready_out, ALU_control, ctrl_valid, busy, done,
               hi, lo, div_by_zero, illegal
    );
endinterface

// File: rtl/alu_funct_decode.sv
// Purely combinational ALU_op/Funct decoder. Every unlisted encoding maps to
// ILLEGAL so the control code is never X.
module alu_funct_decode
    import alu_ctrl_pkg::*;
#(
    parameter bit DIV_EN = 1'b1
) (
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] code_o,
    output logic       is_multi_o
);

    // Map class/function to a control code and flag the iterative ops
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs -- no latch.
        code_o     = ILLEGAL;
        is_multi_o = 1'b0;
        case (alu_op_i)
            2'b00: begin
                case (funct_i)
                    FN_LW, FN_SW: code_o = MEM_W;
                    FN_LB, FN_SB: code_o = ADD;
                    FN_LH, FN_SH: code_o = MEM_H;
                    default:      code_o = ILLEGAL;
                endcase
            end
            2'b01: code_o = SUB;
            2'b10: begin
                case (funct_i)
                    FN_AND, FN_ANDI: code_o = AND;
                    FN_OR,  FN_ORI:  code_o = OR;
                    FN_ADD, FN_ADDI: code_o = ADD;
                    FN_SUB:          code_o = SUB;
                    FN_SLT, FN_SLTI: code_o = SLT;
                    FN_NOR:          code_o = NOR;
                    FN_SLL:          code_o = SLL;
                    FN_SRL:          code_o = SRL;
                    FN_MUL: begin
                        code_o     = MUL;
                        is_multi_o = 1'b1;
                    end
                    FN_DIV: begin
                        if (DIV_EN) begin
                            code_o     = DIV;
                            is_multi_o = 1'b1;
                        end
                    end
                    default: code_o = ILLEGAL;
                endcase
            end
            default: code_o = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with registered control code, plus an iterative
// unsigned shift-add multiplier and restoring divider that stall the pipeline
// while they run.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_ctrl_seq_if.slave bus
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [3:0]         dec_code;
    logic               dec_multi;
    logic               accept, zero_div;

    logic [3:0]         code_q;
    logic               ctrl_valid_q, illegal_q, dbz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    // Working registers: work_hi is accumulator / remainder, work_lo holds
    // the multiplier or dividend and collects product-low or quotient bits.
    logic [WIDTH-1:0]   work_hi_q, work_lo_q, oper_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;

    alu_funct_decode #(.DIV_EN(DIV_EN)) u_decode (
        .alu_op_i   (bus.ALU_op),
        .funct_i    (bus.Funct),
        .code_o     (dec_code),
        .is_multi_o (dec_multi)
    );

    assign accept   = bus.valid_in && (state_q == ST_IDLE);
    assign zero_div = accept && (dec_code == DIV) && (bus.B == '0);

    // One iteration of multiply or divide, from the current working registers
    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, oper_q} : '0);
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, oper_q};
        if (state_q == ST_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {work_lo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {work_lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and state-decoded handshake outputs
    always_comb begin
        state_d       = state_q;
        bus.ready_out = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.ready_out = 1'b1;
                if (zero_div)
                    state_d = ST_FIN;
                else if (accept && dec_multi)
                    state_d = (dec_code == MUL) ? ST_MUL : ST_DIV;
            end
            ST_MUL, ST_DIV: begin
                bus.busy = 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FIN;
            end
            ST_FIN: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control-code register, operand capture, iteration and result latch
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: working registers are reset as well, so an aborted operation
        // leaves nothing behind and hi/lo are never X.
        if (!reset_n) begin
            code_q       <= AND;
            ctrl_valid_q <= 1'b0;
            illegal_q    <= 1'b0;
            dbz_q        <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            work_hi_q    <= '0;
            work_lo_q    <= '0;
            oper_q       <= '0;
            cnt_q        <= '0;
        end else begin
            ctrl_valid_q <= accept;
            illegal_q    <= accept && (dec_code == ILLEGAL);
            if (accept) begin
                code_q <= dec_code;
                dbz_q  <= zero_div;
                if (dec_multi) begin
                    work_hi_q <= '0;
                    work_lo_q <= bus.A;
                    oper_q    <= bus.B;
                    cnt_q     <= '0;
                end
                if (zero_div) begin
                    hi_q <= bus.A;
                    lo_q <= '1;
                end
            end
            if (state_q == ST_MUL || state_q == ST_DIV) begin
                work_hi_q <= step_hi;
                work_lo_q <= step_lo;
                cnt_q     <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    hi_q <= step_hi;
                    lo_q <= step_lo;
                end
            end
        end
    end

    assign bus.ALU_control = code_q;
    assign bus.ctrl_valid  = ctrl_valid_q;
    assign bus.illegal     = illegal_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule
